load_store_unit: RTL and testbench

Load/store unit between the ALU and data memory. Takes the ALU `Result` as the effective address plus the store data and `funct3` from decode, and runs one handshaked transaction on a word-wide memory port. Generates byte enables and replicated store lanes, sign- or zero-extends load data, and stalls the core until the access retires. It flags misaligned or illegal accesses without touching memory.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_align.sv | 38 +++
 rtl/load_store_unit.sv | 122 ++++++++++++
 tb/tb_load_store_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3[1:0] encodes the access size for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
    if (we) begin
      return !(funct3 inside {F3_B, F3_H, F3_W});
    end
    return !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: byte enables, replicated store data and extended load data.
// Purely combinational, no latency, no flow control of its own.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {addr_lo_i, 3'b000};
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = shifted;
    case (funct3_i)
      F3_B, F3_BU: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        // funct3[2] set marks the unsigned variants
        rdata_o = {{24{shifted[7] & ~funct3_i[2]}}, shifted[7:0]};
      end
      F3_H, F3_HU: begin
        be_o    = 4'b0011 << addr_lo_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{shifted[15] & ~funct3_i[2]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// One handshaked word-port access per Req; store 2 cycles, load 3+ cycles, error 1 cycle.
// Core is stalled until Done; memory stalls via mem_gnt / mem_rvalid, accesses are never cancelled.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Req,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [2:0]            funct3,
  input  logic [31:0]           WriteData,
  output logic [31:0]           ReadData,
  output logic                  Done,
  output logic                  Stall,
  output logic                  Error,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata
);

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            f3_q, f3_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [3:0]            be;
  logic [31:0]           wdata_rep;
  logic [31:0]           load_ext;
  logic                  acc_err;

  lsu_align u_align (
    .funct3_i  (f3_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rdata_i   (mem_rdata),
    .be_o      (be),
    .wdata_o   (wdata_rep),
    .rdata_o   (load_ext)
  );

  assign acc_err = is_illegal(WE, funct3) | is_misaligned(funct3, Addr[1:0]);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (Req) begin
          we_d    = WE;
          addr_d  = Addr;
          f3_d    = funct3;
          wdata_d = WriteData;
          rdata_d = '0;
          err_d   = acc_err;
          state_d = acc_err ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          state_d = we_q ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = load_ext;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      f3_q    <= 3'b000;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory-side fields are state-decoded so reset removes them immediately.
  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_be    = mem_req ? be : 4'b0000;
  assign mem_wdata = (mem_req & we_q) ? wdata_rep : 32'h0;

  assign Done      = (state_q == S_DONE);
  assign Error     = Done & err_q;
  assign ReadData  = rdata_q;
  assign Stall     = Req & ~Done;

endmodule

// File: tb/tb_load_store_unit.sv
// Vector-table and scoreboard bench for load_store_unit, plus reset-in-flight sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Req = 1'b0;
  logic        WE = 1'b0;
  logic [31:0] Addr = 32'h0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] WriteData = 32'h0;
  logic [31:0] ReadData;
  logic        Done;
  logic        Stall;
  logic        Error;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .Req        (Req),
    .WE         (WE),
    .Addr       (Addr),
    .funct3     (funct3),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .Done       (Done),
    .Stall      (Stall),
    .Error      (Error),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [31:0] rd;
    int          g;      // cycles mem_gnt is held low in REQ
    int          rv;     // cycles from grant to mem_rvalid
    logic        drop;   // core drops Req after acceptance
    logic        err;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] erd;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[15];

  function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [2:0] f3,
                              input logic [31:0] wd, input logic [31:0] rd, input int g, input int rv,
                              input logic drop, input logic err, input logic [31:0] ma,
                              input logic [3:0] be, input logic [31:0] mwd, input logic [31:0] erd);
    vec_t v;
    v.we = we; v.addr = a; v.f3 = f3; v.wd = wd; v.rd = rd; v.g = g; v.rv = rv;
    v.drop = drop; v.err = err; v.maddr = ma; v.be = be; v.mwd = mwd; v.erd = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Entered and left at negedge+1; the cycle after Done is the next accept cycle.
  task automatic run_vec(input vec_t v, input int idx);
    exp_t e, got;
    int   cyc, req_cnt, gcyc, dones, done_cyc;
    bit   saw_req, stall_bad, idle_bad;
    e.rd  = v.erd;
    e.err = v.err;
    e.lat = v.err ? 1 : (v.we ? 2 + v.g : 2 + v.g + v.rv);
    sb.push_back(e);
    Req = 1'b1; WE = v.we; Addr = v.addr; funct3 = v.f3; WriteData = v.wd;
    mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'hDEADBEEF;
    cyc = 0; req_cnt = 0; gcyc = -1; dones = 0; done_cyc = -1;
    saw_req = 0; stall_bad = 0; idle_bad = 0;
    while (dones == 0 && cyc < 40) begin
      #1;
      if (Stall !== (Req && (cyc != e.lat))) stall_bad = 1;
      if (!mem_req && (mem_we !== 1'b0 || mem_be !== 4'b0 || mem_wdata !== 32'h0)) idle_bad = 1;
      if (mem_req && !saw_req) begin
        saw_req = 1;
        chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.maddr);
        chk($sformatf("v%0d_mem_be", idx), {28'h0, mem_be}, {28'h0, v.be});
        chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.mwd);
        chk($sformatf("v%0d_mem_we", idx), {31'h0, mem_we}, {31'h0, v.we});
      end
      if (Done) begin
        dones++;
        done_cyc = cyc;
        if (sb.size() > 0) begin
          got = sb.pop_front();
          chk($sformatf("v%0d_ReadData", idx), ReadData, got.rd);
          chk($sformatf("v%0d_Error", idx), {31'h0, Error}, {31'h0, got.err});
          chk($sformatf("v%0d_latency", idx), done_cyc, got.lat);
        end
        Req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'hDEADBEEF;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hDEADBEEF;
        if (mem_req) begin
          mem_gnt = (req_cnt >= v.g);
          if (mem_gnt && !v.we) gcyc = cyc;
          if (!mem_gnt && !v.we) mem_rvalid = 1'b1;  // stray rvalid outside WAIT
          req_cnt++;
        end else begin
          mem_gnt = 1'b1;
          if (gcyc >= 0 && cyc == gcyc + v.rv) begin
            mem_rvalid = 1'b1;
            mem_rdata  = v.rd;
          end
        end
        if (v.drop && cyc >= 1) Req = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    if (dones == 0) begin
      chk($sformatf("v%0d_done_timeout", idx), 32'd0, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    #1;
    chk($sformatf("v%0d_mem_req_seen", idx), {31'h0, saw_req}, {31'h0, ~v.err});
    chk($sformatf("v%0d_stall", idx), {31'h0, stall_bad}, 32'h0);
    chk($sformatf("v%0d_idle_zero", idx), {31'h0, idle_bad}, 32'h0);
    chk($sformatf("v%0d_single_done", idx), {31'h0, Done}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount;
    //               we  addr          f3   wdata         rdata         g  rv drop err maddr         be       mwdata        ReadData
    vecs[0]  = mk(1, 32'h0000_1003, 3'b000, 32'hAABBCCDD, 32'h0,        0, 1, 0, 0, 32'h0000_1000, 4'b1000, 32'hDDDDDDDD, 32'h0);
    vecs[1]  = mk(0, 32'h0000_2001, 3'b000, 32'h0,        32'h1234F678, 0, 1, 0, 0, 32'h0000_2000, 4'b0010, 32'h0,        32'hFFFFFFF6);
    vecs[2]  = mk(0, 32'h0000_2001, 3'b100, 32'h0,        32'h1234F678, 0, 1, 0, 0, 32'h0000_2000, 4'b0010, 32'h0,        32'h000000F6);
    vecs[3]  = mk(0, 32'h0000_2002, 3'b001, 32'h0,        32'h80011234, 0, 1, 0, 0, 32'h0000_2000, 4'b1100, 32'h0,        32'hFFFF8001);
    vecs[4]  = mk(0, 32'h0000_3002, 3'b010, 32'h0,        32'h0,        0, 1, 0, 1, 32'h0,         4'b0000, 32'h0,        32'h0);
    vecs[5]  = mk(0, 32'h0000_4000, 3'b010, 32'h0,        32'hCAFEBABE, 3, 2, 0, 0, 32'h0000_4000, 4'b1111, 32'h0,        32'hCAFEBABE);
    vecs[6]  = mk(1, 32'h0000_5002, 3'b001, 32'h11223344, 32'h0,        0, 1, 0, 0, 32'h0000_5000, 4'b1100, 32'h33443344, 32'h0);
    vecs[7]  = mk(1, 32'h0000_6000, 3'b010, 32'h89ABCDEF, 32'h0,        1, 1, 0, 0, 32'h0000_6000, 4'b1111, 32'h89ABCDEF, 32'h0);
    vecs[8]  = mk(0, 32'h0000_7000, 3'b101, 32'h0,        32'h1234ABCD, 0, 1, 0, 0, 32'h0000_7000, 4'b0011, 32'h0,        32'h0000ABCD);
    vecs[9]  = mk(0, 32'h0000_8000, 3'b011, 32'h0,        32'h0,        0, 1, 0, 1, 32'h0,         4'b0000, 32'h0,        32'h0);
    vecs[10] = mk(1, 32'h0000_8004, 3'b100, 32'h55555555, 32'h0,        0, 1, 0, 1, 32'h0,         4'b0000, 32'h0,        32'h0);
    vecs[11] = mk(1, 32'h0000_9001, 3'b001, 32'h12345678, 32'h0,        0, 1, 0, 1, 32'h0,         4'b0000, 32'h0,        32'h0);
    vecs[12] = mk(0, 32'h0000_A003, 3'b000, 32'h0,        32'h7F000000, 0, 1, 0, 0, 32'h0000_A000, 4'b1000, 32'h0,        32'h0000007F);
    vecs[13] = mk(0, 32'h0000_B000, 3'b001, 32'h0,        32'h00007FFF, 0, 1, 1, 0, 32'h0000_B000, 4'b0011, 32'h0,        32'h00007FFF);
    vecs[14] = mk(0, 32'h0000_C004, 3'b010, 32'h0,        32'hFFFFFFFF, 0, 3, 0, 0, 32'h0000_C004, 4'b1111, 32'h0,        32'hFFFFFFFF);

    #12;
    chk("rst_mem_req",   {31'h0, mem_req}, 32'h0);
    chk("rst_mem_we",    {31'h0, mem_we}, 32'h0);
    chk("rst_mem_be",    {28'h0, mem_be}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_addr",  mem_addr, 32'h0);
    chk("rst_ReadData",  ReadData, 32'h0);
    chk("rst_Done",      {31'h0, Done}, 32'h0);
    chk("rst_Error",     {31'h0, Error}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset while REQ is waiting for a grant.
    Req = 1'b1; WE = 1'b0; Addr = 32'h0000_0200; funct3 = F3_W_TB(); mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk); #1;
    chk("rreq_mem_req_before", {31'h0, mem_req}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rreq_mem_req_after", {31'h0, mem_req}, 32'h0);
    chk("rreq_mem_addr",      mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0; Req = 1'b0; mem_gnt = 1'b1;
    @(negedge clk); #1;

    // Reset in WAIT, then a late rvalid must not produce Done.
    Req = 1'b1; WE = 1'b0; Addr = 32'h0000_0100; funct3 = F3_W_TB(); mem_gnt = 1'b1;
    @(negedge clk); #1;
    chk("rwait_granted", {31'h0, mem_req}, 32'h1);
    @(negedge clk); #1;
    chk("rwait_in_wait", {31'h0, mem_req}, 32'h0);
    rst = 1'b1;
    #1;
    chk("rwait_mem_req",  {31'h0, mem_req}, 32'h0);
    chk("rwait_mem_addr", mem_addr, 32'h0);
    chk("rwait_Done",     {31'h0, Done}, 32'h0);
    @(negedge clk);
    rst = 1'b0; Req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    dcount = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      if (Done) dcount++;
    end
    mem_rvalid = 1'b0;
    chk("rwait_late_rvalid_done", dcount, 32'd0);
    chk("rwait_ReadData",         ReadData, 32'h0);
    chk("scoreboard_empty",       sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic [2:0] F3_W_TB();
    return 3'b010;
  endfunction

endmodule
